div_scheduler: RTL and testbench

DIV_SCHEDULER -- requirements
Module: div_scheduler

---
 rtl/div_pkg.sv | 20 ++
 rtl/rr_arbiter.sv | 43 ++++
 rtl/div_scheduler.sv | 165 ++++++++++++++++
 tb/tb_div_scheduler.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : div_pkg
//  Description : Shared widths and FSM state encoding for the divider scheduler.
//  Revision    : 1.0 - initial release
// ============================================================================
package div_pkg;

    localparam int ARG_BIT_WIDTH = 32;
    localparam int PRECISION     = 64;
    localparam int RESULT_W      = ARG_BIT_WIDTH + PRECISION;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter
//  Description : Combinational round-robin grant; search starts at ptr and
//                wraps, producing a one-hot (or zero) grant vector.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] grant
);

    localparam logic [ID_W:0] c_num_req = (ID_W + 1)'(NUM_REQ);

    logic [ID_W:0]   w_pos;
    logic [ID_W-1:0] w_idx;
    logic            w_found;

    always_comb begin
        grant   = '0;
        w_found = 1'b0;
        w_pos   = '0;
        w_idx   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            // Extra bit keeps ptr+i from overflowing before the modulo wrap.
            w_pos = {1'b0, ptr} + (ID_W + 1)'(i);
            if (w_pos >= c_num_req) begin
                w_pos = w_pos - c_num_req;
            end
            w_idx = w_pos[ID_W-1:0];
            if (!w_found && req[w_idx]) begin
                grant[w_idx] = 1'b1;
                w_found      = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/div_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : div_scheduler
//  Description : Shares one external divider among NUM_REQ requesters with a
//                round-robin grant and a single outstanding transaction.
//  Revision    : 1.0 - initial release
// ============================================================================
module div_scheduler
    import div_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int DIV_LATENCY = 2
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_REQ-1:0]               req_valid,
    output logic [NUM_REQ-1:0]               req_ready,
    input  logic [NUM_REQ*ARG_BIT_WIDTH-1:0] req_a,
    input  logic [NUM_REQ*ARG_BIT_WIDTH-1:0] req_b,
    output logic                             rsp_valid,
    input  logic                             rsp_ready,
    output logic [$clog2(NUM_REQ)-1:0]       rsp_id,
    output logic [RESULT_W-1:0]              rsp_result,
    output logic                             rsp_dz,
    output logic [ARG_BIT_WIDTH-1:0]         div_a,
    output logic [ARG_BIT_WIDTH-1:0]         div_b,
    input  logic [RESULT_W-1:0]              div_result,
    input  logic                             div_dz
);

    localparam int             ID_W       = $clog2(NUM_REQ);
    localparam logic [3:0]     c_lat_load = 4'(DIV_LATENCY - 1);
    localparam logic [ID_W-1:0] c_last_id = ID_W'(NUM_REQ - 1);

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic [ID_W-1:0]          r_rr_ptr;
    logic [ID_W-1:0]          r_tag;
    logic [3:0]               r_count;
    logic [ARG_BIT_WIDTH-1:0] r_op_a;
    logic [ARG_BIT_WIDTH-1:0] r_op_b;
    logic [RESULT_W-1:0]      r_result;
    logic                     r_dz;

    logic [NUM_REQ-1:0]       w_grant;
    logic [ID_W-1:0]          w_grant_id;
    logic [ID_W-1:0]          w_ptr_nxt;
    logic [ARG_BIT_WIDTH-1:0] w_sel_a;
    logic [ARG_BIT_WIDTH-1:0] w_sel_b;
    logic                     w_accept;
    logic                     w_div_zero;
    logic                     w_div_done;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr_arbiter (
        .req   (req_valid),
        .ptr   (r_rr_ptr),
        .grant (w_grant)
    );

    always_comb begin
        w_sel_a    = '0;
        w_sel_b    = '0;
        w_grant_id = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_grant[i]) begin
                w_sel_a    = req_a[i*ARG_BIT_WIDTH +: ARG_BIT_WIDTH];
                w_sel_b    = req_b[i*ARG_BIT_WIDTH +: ARG_BIT_WIDTH];
                w_grant_id = ID_W'(i);
            end
        end
    end

    always_comb begin
        w_ptr_nxt = (w_grant_id == c_last_id) ? '0 : w_grant_id + ID_W'(1);
    end

    // rst gates the grant directly so no accept can leak while reset is held.
    assign req_ready  = (r_state == IDLE && !rst) ? w_grant : '0;
    assign w_accept   = |(req_valid & req_ready);
    assign w_div_zero = (w_sel_b == '0);
    assign w_div_done = (r_count == 4'd0);

    assign rsp_valid  = (r_state == RESP);
    assign rsp_id     = r_tag;
    assign rsp_result = r_result;
    assign rsp_dz     = r_dz;
    assign div_a      = r_op_a;
    assign div_b      = r_op_b;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_nxt = w_div_zero ? RESP : BUSY;
                end
            end
            BUSY: begin
                if (w_div_done) begin
                    w_state_nxt = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rr_ptr <= '0;
            r_tag    <= '0;
            r_count  <= '0;
            r_op_a   <= '0;
            r_op_b   <= '0;
            r_result <= '0;
            r_dz     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_op_a   <= w_sel_a;
                        r_op_b   <= w_sel_b;
                        r_tag    <= w_grant_id;
                        r_rr_ptr <= w_ptr_nxt;
                        // A zero divisor never reaches the divider; answer at once.
                        if (w_div_zero) begin
                            r_result <= '0;
                            r_dz     <= 1'b1;
                            r_count  <= 4'd0;
                        end else begin
                            r_count  <= c_lat_load;
                        end
                    end
                end
                BUSY: begin
                    if (w_div_done) begin
                        r_result <= div_result;
                        r_dz     <= div_dz;
                    end else begin
                        r_count  <= r_count - 4'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_div_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_div_scheduler
//  Description : Self-checking bench for div_scheduler with a divider model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_div_scheduler;

    localparam int NUM_REQ     = 4;
    localparam int DIV_LATENCY = 2;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [3:0]   req_valid = '0;
    logic [3:0]   req_ready;
    logic [127:0] req_a;
    logic [127:0] req_b;
    logic         rsp_valid;
    logic         rsp_ready = 1'b0;
    logic [1:0]   rsp_id;
    logic [95:0]  rsp_result;
    logic         rsp_dz;
    logic [31:0]  div_a;
    logic [31:0]  div_b;
    logic [95:0]  div_result;
    logic         div_dz;

    logic [31:0]  a_arr [4];
    logic [31:0]  b_arr [4];
    int           cyc = 0;
    int           n_tests = 0;
    int           n_fail = 0;
    int           m_ptr = 0;

    div_scheduler #(
        .NUM_REQ     (NUM_REQ),
        .DIV_LATENCY (DIV_LATENCY)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_result (rsp_result),
        .rsp_dz     (rsp_dz),
        .div_a      (div_a),
        .div_b      (div_b),
        .div_result (div_result),
        .div_dz     (div_dz)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always_comb begin
        req_a = '0;
        req_b = '0;
        for (int i = 0; i < 4; i++) begin
            req_a[i*32 +: 32] = a_arr[i];
            req_b[i*32 +: 32] = b_arr[i];
        end
    end

    // Divider model: returns junk for a zero divisor so a bypass failure shows.
    assign div_result = (div_b == 32'd0) ? {96{1'b1}} : ({div_a, 64'd0} / {64'd0, div_b});
    assign div_dz     = (div_b == 32'd0);

    function automatic logic [95:0] model_quot(input logic [31:0] a, input logic [31:0] b);
        if (b == 32'd0) return 96'd0;
        return {a, 64'd0} / {64'd0, b};
    endfunction

    function automatic int model_grant(input logic [3:0] mask);
        for (int k = 0; k < 4; k++) begin
            if (mask[(m_ptr + k) % 4]) return (m_ptr + k) % 4;
        end
        return -1;
    endfunction

    function automatic int model_lat(input logic [31:0] b);
        return (b == 32'd0) ? 1 : 1 + DIV_LATENCY;
    endfunction

    function automatic logic [31:0] rand_b();
        return ($urandom_range(0, 3) == 0) ? 32'd0 : 32'($urandom);
    endfunction

    // All helpers start and end just after a falling edge.
    task automatic wait_accept(output int g, output int t, output bit to);
        bit done;
        g = -1; t = 0; to = 1'b1; done = 1'b0;
        for (int n = 0; n < 40 && !done; n++) begin
            #1;
            if ((req_valid & req_ready) != 4'd0) begin
                for (int i = 0; i < 4; i++) if (req_ready[i]) g = i;
                t = cyc; to = 1'b0; done = 1'b1;
            end
            @(negedge clk);
        end
    endtask

    task automatic wait_rsp(output int t, output bit to);
        bit done;
        t = 0; to = 1'b1; done = 1'b0;
        for (int n = 0; n < 40 && !done; n++) begin
            #1;
            if (rsp_valid) begin
                t = cyc; to = 1'b0; done = 1'b1;
            end else begin
                @(negedge clk);
            end
        end
    endtask

    task automatic consume(input int d);
        repeat (d) @(negedge clk);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = 4'hF; rsp_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin a_arr[i] = $urandom; b_arr[i] = $urandom; end
        repeat (3) @(negedge clk);
        #1;
        n_tests++; if (req_ready !== 4'd0) begin n_fail++; $display("FAIL reset_req_ready got %h exp 0", req_ready); end
        n_tests++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid got %b exp 0", rsp_valid); end
        n_tests++; if (div_a !== 32'd0) begin n_fail++; $display("FAIL reset_div_a got %h exp 0", div_a); end
        n_tests++; if (div_b !== 32'd0) begin n_fail++; $display("FAIL reset_div_b got %h exp 0", div_b); end
        n_tests++; if (rsp_id !== 2'd0) begin n_fail++; $display("FAIL reset_rsp_id got %0d exp 0", rsp_id); end
        n_tests++; if (rsp_result !== 96'd0) begin n_fail++; $display("FAIL reset_rsp_result got %h exp 0", rsp_result); end
        n_tests++; if (rsp_dz !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_dz got %b exp 0", rsp_dz); end
        @(negedge clk);
        req_valid = 4'd0; rst = 1'b0; m_ptr = 0;
        @(negedge clk);
    endtask

    task automatic test_single();
        int g, t, tr; bit to;
        a_arr[0] = 32'd10; b_arr[0] = 32'd4; req_valid = 4'b0001;
        wait_accept(g, t, to);
        n_tests++; if (to || g !== 0) begin n_fail++; $display("FAIL single_grant got %0d (timeout %b) exp 0", g, to); end
        m_ptr = 1; req_valid = 4'd0;
        #1;
        n_tests++; if (div_a !== 32'd10 || div_b !== 32'd4) begin n_fail++; $display("FAIL single_div_ops got %0d/%0d exp 10/4", div_a, div_b); end
        n_tests++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL single_busy_rsp_valid got %b exp 0", rsp_valid); end
        wait_rsp(tr, to);
        n_tests++; if (to || tr != t + 3) begin n_fail++; $display("FAIL single_latency got %0d (timeout %b) exp 3", tr - t, to); end
        n_tests++; if (rsp_id !== 2'd0) begin n_fail++; $display("FAIL single_rsp_id got %0d exp 0", rsp_id); end
        n_tests++; if (rsp_result !== 96'h2_8000_0000_0000_0000) begin n_fail++; $display("FAIL single_result got %h exp 28000000000000000", rsp_result); end
        n_tests++; if (rsp_dz !== 1'b0) begin n_fail++; $display("FAIL single_dz got %b exp 0", rsp_dz); end
        consume(0);
        #1;
        n_tests++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL single_rsp_drop got %b exp 0", rsp_valid); end
    endtask

    task automatic test_div_zero();
        int g, t, tr; bit to;
        a_arr[2] = 32'd7; b_arr[2] = 32'd0; req_valid = 4'b0100;
        wait_accept(g, t, to);
        n_tests++; if (to || g !== 2) begin n_fail++; $display("FAIL dz_grant got %0d (timeout %b) exp 2", g, to); end
        m_ptr = 3; req_valid = 4'd0;
        wait_rsp(tr, to);
        n_tests++; if (to || tr != t + 1) begin n_fail++; $display("FAIL dz_latency got %0d (timeout %b) exp 1", tr - t, to); end
        n_tests++; if (rsp_id !== 2'd2) begin n_fail++; $display("FAIL dz_rsp_id got %0d exp 2", rsp_id); end
        n_tests++; if (rsp_result !== 96'd0) begin n_fail++; $display("FAIL dz_result got %h exp 0", rsp_result); end
        n_tests++; if (rsp_dz !== 1'b1) begin n_fail++; $display("FAIL dz_flag got %b exp 1", rsp_dz); end
        consume(0);
    endtask

    task automatic test_reset_mid_busy();
        int g, t, tr, seen; bit to;
        a_arr[1] = $urandom; b_arr[1] = 32'($urandom) | 32'd1; req_valid = 4'b0010;
        wait_accept(g, t, to);
        n_tests++; if (to || g !== model_grant(4'b0010)) begin n_fail++; $display("FAIL rstbusy_grant got %0d exp 1", g); end
        req_valid = 4'hF; rst = 1'b1;
        #1;
        n_tests++; if (req_ready !== 4'd0 || rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rstbusy_outputs got ready %h valid %b exp 0 0", req_ready, rsp_valid); end
        n_tests++; if (div_a !== 32'd0) begin n_fail++; $display("FAIL rstbusy_async_clear got %h exp 0", div_a); end
        @(negedge clk);
        rst = 1'b0; req_valid = 4'd0; m_ptr = 0; seen = 0;
        for (int n = 0; n < 6; n++) begin
            #1; if (rsp_valid) seen++;
            @(negedge clk);
        end
        n_tests++; if (seen != 0) begin n_fail++; $display("FAIL rstbusy_no_rsp got %0d exp 0", seen); end
        for (int i = 0; i < 4; i++) begin a_arr[i] = $urandom; b_arr[i] = rand_b(); end
        req_valid = 4'hF;
        wait_accept(g, t, to);
        n_tests++; if (to || g !== 0) begin n_fail++; $display("FAIL rstbusy_next_grant got %0d exp 0", g); end
        m_ptr = 1; req_valid = 4'd0;
        wait_rsp(tr, to);
        n_tests++; if (to || rsp_id !== 2'd0) begin n_fail++; $display("FAIL rstbusy_rsp_id got %0d exp 0", rsp_id); end
        consume(0);
    endtask

    task automatic test_fairness();
        int g, e, t, tr; bit to; logic [31:0] ea, eb;
        rst = 1'b1; @(negedge clk); rst = 1'b0; m_ptr = 0;
        for (int i = 0; i < 4; i++) begin a_arr[i] = $urandom; b_arr[i] = rand_b(); end
        req_valid = 4'hF;
        for (int k = 0; k < 8; k++) begin
            e = model_grant(4'hF);
            wait_accept(g, t, to);
            n_tests++; if (to || g !== e || e != k % 4) begin n_fail++; $display("FAIL fair_order[%0d] got %0d exp %0d", k, g, k % 4); end
            ea = a_arr[e]; eb = b_arr[e]; m_ptr = (e + 1) % 4;
            a_arr[e] = $urandom; b_arr[e] = rand_b();
            wait_rsp(tr, to);
            n_tests++; if (to || tr != t + model_lat(eb)) begin n_fail++; $display("FAIL fair_latency[%0d] got %0d exp %0d", k, tr - t, model_lat(eb)); end
            n_tests++; if (rsp_id !== 2'(e) || rsp_result !== model_quot(ea, eb) || rsp_dz !== (eb == 0)) begin
                n_fail++; $display("FAIL fair_rsp[%0d] got id %0d res %h dz %b exp id %0d res %h dz %b", k, rsp_id, rsp_result, rsp_dz, e, model_quot(ea, eb), eb == 0);
            end
            consume(0);
        end
        req_valid = 4'd0;
    endtask

    task automatic test_backpressure();
        int g, e, t, tr; bit to; logic [31:0] ea, eb;
        for (int i = 0; i < 4; i++) begin a_arr[i] = $urandom; b_arr[i] = 32'($urandom) | 32'd1; end
        req_valid = 4'hF;
        e = model_grant(4'hF);
        wait_accept(g, t, to);
        n_tests++; if (to || g !== e) begin n_fail++; $display("FAIL bp_grant got %0d exp %0d", g, e); end
        ea = a_arr[e]; eb = b_arr[e]; m_ptr = (e + 1) % 4;
        req_valid[e] = 1'b0;
        wait_rsp(tr, to);
        n_tests++; if (to) begin n_fail++; $display("FAIL bp_rsp_timeout got none exp response"); end
        for (int n = 0; n < 5; n++) begin
            n_tests++; if (rsp_valid !== 1'b1 || rsp_id !== 2'(e) || rsp_result !== model_quot(ea, eb) || req_ready !== 4'd0) begin
                n_fail++; $display("FAIL bp_hold[%0d] got v %b id %0d res %h rdy %h exp 1 %0d %h 0", n, rsp_valid, rsp_id, rsp_result, req_ready, e, model_quot(ea, eb));
            end
            @(negedge clk); #1;
        end
        consume(0);
        #1;
        n_tests++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL bp_single_rsp got %b exp 0", rsp_valid); end
        e = model_grant(req_valid);
        wait_accept(g, t, to);
        n_tests++; if (to || g !== e) begin n_fail++; $display("FAIL bp_stalled_grant got %0d exp %0d", g, e); end
        m_ptr = (e + 1) % 4; req_valid = 4'd0;
        wait_rsp(tr, to);
        consume(0);
    endtask

    task automatic test_skip();
        int g, t, tr; bit to;
        req_valid = 4'b0010;
        wait_accept(g, t, to);
        m_ptr = 2; req_valid = 4'd0;
        wait_rsp(tr, to); consume(0);
        req_valid = 4'b1010;
        wait_accept(g, t, to);
        n_tests++; if (to || g !== 3 || g !== model_grant(4'b1010)) begin n_fail++; $display("FAIL skip_first got %0d exp 3", g); end
        m_ptr = 0; req_valid = 4'b0010;
        wait_rsp(tr, to); consume(0);
        wait_accept(g, t, to);
        n_tests++; if (to || g !== 1) begin n_fail++; $display("FAIL skip_second got %0d exp 1", g); end
        m_ptr = 2; req_valid = 4'd0;
        wait_rsp(tr, to); consume(0);
    endtask

    task automatic test_random();
        int g, e, t, tr; bit to; logic [3:0] mask; logic [31:0] ea, eb;
        for (int k = 0; k < 12; k++) begin
            for (int i = 0; i < 4; i++) begin a_arr[i] = $urandom; b_arr[i] = rand_b(); end
            mask = 4'($urandom_range(1, 15));
            req_valid = mask;
            e = model_grant(mask);
            wait_accept(g, t, to);
            n_tests++; if (to || g !== e) begin n_fail++; $display("FAIL rand_grant[%0d] got %0d exp %0d", k, g, e); end
            ea = a_arr[e]; eb = b_arr[e]; m_ptr = (e + 1) % 4; req_valid = 4'd0;
            wait_rsp(tr, to);
            n_tests++; if (to || tr != t + model_lat(eb) || rsp_id !== 2'(e) || rsp_result !== model_quot(ea, eb) || rsp_dz !== (eb == 0)) begin
                n_fail++; $display("FAIL rand_rsp[%0d] got lat %0d id %0d res %h dz %b exp lat %0d id %0d res %h", k, tr - t, rsp_id, rsp_result, rsp_dz, model_lat(eb), e, model_quot(ea, eb));
            end
            consume($urandom_range(0, 3));
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_div_zero();
        test_reset_mid_busy();
        test_fairness();
        test_backpressure();
        test_skip();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got no finish exp finish");
        $fatal(1);
    end

endmodule
`default_nettype wire
